// File: rtl/coproc_pixel_seq.sv
// Frame sequencer: streams every pixel of the image RAM through the pixel ALU
// and writes each result back in place, sustaining one pixel per clock.
module coproc_pixel_seq #(
    parameter int NUM_PIXELS = 19200,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        func,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [11:0]       alu_pixel_in,
    output logic [1:0]        alu_func,
    input  logic [11:0]       alu_pixel_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_count;
    logic [ADDR_W-1:0] s1_addr;
    logic [1:0]        func_q;
    logic              s1_valid;
    logic              wr_valid;
    logic              accept;
    logic              abort_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving DRAIN once stage 1 is empty: the write stage retires its last
    // pixel in that same cycle, so DONE lands one cycle after the final write.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        abort_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = DRAIN;
                end else begin
                    rd_en = 1'b1;
                    if (rd_count == LAST_ADDR) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr = rd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            func_q   <= '0;
            aborted  <= 1'b0;
        end else begin
            if (accept) begin
                rd_count <= '0;
                func_q   <= func;
                aborted  <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_count <= rd_count + ADDR_W'(1);
                end
                if (abort_hit) begin
                    aborted <= 1'b1;
                end
            end
        end
    end

    // Two-stage pipeline: stage 1 presents RAM data to the ALU, stage 2 holds
    // the ALU result and its address for the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_addr  <= rd_addr;
            wr_valid <= s1_valid;
            wr_addr  <= s1_addr;
            wr_data  <= alu_pixel_out;
        end
    end

    assign wr_en        = wr_valid;
    assign alu_pixel_in = s1_valid ? rd_data : 12'h000;
    assign alu_func     = s1_valid ? func_q : 2'b00;

endmodule

// File: tb/tb_coproc_pixel_seq.sv
// Self-checking bench for coproc_pixel_seq with a RAM model, an ALU model and
// a frame-level reference of the expected image after each pass.
module tb_coproc_pixel_seq;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    func;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic [11:0]   alu_pixel_in;
    logic [1:0]    alu_func;
    logic [11:0]   alu_pixel_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    logic [11:0] mem [N];
    logic [11:0] load_img [N];
    logic        load_req;
    logic [11:0] model [N];

    int checks;
    int errors;

    coproc_pixel_seq #(.NUM_PIXELS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_pixel_in(alu_pixel_in), .alu_func(alu_func), .alu_pixel_out(alu_pixel_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel (4:4:4) pixel operations of the ALU
    function automatic logic [11:0] alu_model(input logic [1:0] f, input logic [11:0] p);
        logic [11:0] r;
        int ch;
        r = 12'h000;
        case (f)
            2'b00: r = ~p;
            2'b01: r = {p[7:0], p[11:8]};
            default: begin
                for (int i = 0; i < 3; i++) begin
                    ch = int'(p[i*4 +: 4]);
                    if (f == 2'b10) ch = (ch < 4) ? 0 : ((ch > 11) ? 15 : (ch - 4) * 2);
                    else            ch = (ch >= 7) ? 15 : 0;
                    r[i*4 +: 4] = 4'(ch);
                end
            end
        endcase
        return r;
    endfunction

    assign alu_pixel_out = alu_model(alu_func, alu_pixel_in);

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= load_img[i];
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    task automatic load_ram();
        for (int i = 0; i < N; i++) load_img[i] = model[i];
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic randomize_model();
        for (int i = 0; i < N; i++) model[i] = 12'($urandom);
    endtask

    task automatic check_ram(input string name);
        for (int a = 0; a < N; a++) begin
            checks++;
            if (mem[a] !== model[a]) begin
                errors++;
                $display("[TB] FAIL %s ram[%0d]: got %h expected %h", name, a, mem[a], model[a]);
            end
        end
    endtask

    // Runs one pass starting at a negedge in IDLE and checks every cycle up to
    // done; r reads are expected, then writes two cycles later, then done.
    task automatic drive_pass(input string name, input logic [1:0] f, input int abort_cycle,
                              input int poke_cycle, input bit hold_at_end);
        int r;
        logic        e_alu;
        logic [11:0] e_pix;
        r = (abort_cycle > 0) ? abort_cycle - 1 : N;
        func  = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= r + 3; c++) begin
            abort = (c == abort_cycle);
            start = (c == poke_cycle) || (hold_at_end && c == r + 3);
            func  = (poke_cycle > 0 && c >= poke_cycle) ? ~f : f;
            #1;
            checks++;
            if (rd_en !== (c <= r)) begin
                errors++;
                $display("[TB] FAIL %s rd_en cyc %0d: got %b expected %b", name, c, rd_en, (c <= r));
            end
            if (c <= r) begin
                checks++;
                if (rd_addr !== AW'(c - 1)) begin
                    errors++;
                    $display("[TB] FAIL %s rd_addr cyc %0d: got %0d expected %0d", name, c, rd_addr, c - 1);
                end
            end
            checks++;
            if (wr_en !== (c >= 3 && c <= r + 2)) begin
                errors++;
                $display("[TB] FAIL %s wr_en cyc %0d: got %b expected %b", name, c, wr_en, (c >= 3 && c <= r + 2));
            end
            if (c >= 3 && c <= r + 2) begin
                checks++;
                if (wr_addr !== AW'(c - 3) || wr_data !== alu_model(f, model[c - 3])) begin
                    errors++;
                    $display("[TB] FAIL %s write cyc %0d: got %0d/%h expected %0d/%h", name, c,
                             wr_addr, wr_data, c - 3, alu_model(f, model[c - 3]));
                end
            end
            e_alu = (c >= 2 && c <= r + 1);
            e_pix = e_alu ? model[c - 2] : 12'h000;
            checks++;
            if (alu_pixel_in !== e_pix || alu_func !== (e_alu ? f : 2'b00)) begin
                errors++;
                $display("[TB] FAIL %s alu inputs cyc %0d: got %h/%b expected %h/%b", name, c,
                         alu_pixel_in, alu_func, e_pix, (e_alu ? f : 2'b00));
            end
            checks++;
            if (busy !== (c <= r + 2) || done !== (c == r + 3)) begin
                errors++;
                $display("[TB] FAIL %s busy/done cyc %0d: got %b/%b expected %b/%b", name, c,
                         busy, done, (c <= r + 2), (c == r + 3));
            end
            if (c == r + 3) begin
                checks++;
                if (aborted !== (abort_cycle > 0)) begin
                    errors++;
                    $display("[TB] FAIL %s aborted: got %b expected %b", name, aborted, (abort_cycle > 0));
                end
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = hold_at_end;
        func  = f;
        for (int a = 0; a < r; a++) model[a] = alu_model(f, model[a]);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, aborted, rd_en, wr_en, rd_addr, wr_addr, wr_data, alu_pixel_in, alu_func} !== '0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got %b%b%b%b%b %h %h %h %h %b expected all zero",
                     busy, done, aborted, rd_en, wr_en, rd_addr, wr_addr, wr_data, alu_pixel_in, alu_func);
        end
    endtask

    task automatic test_invert();
        randomize_model();
        model[0] = 12'h123; model[1] = 12'h000; model[2] = 12'hFFF; model[3] = 12'h5A0;
        load_ram();
        drive_pass("invert", 2'b00, 0, 0, 1'b0);
        check_ram("invert");
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 48'hEDC_FFF_000_A5F) begin
            errors++;
            $display("[TB] FAIL invert known: got %h %h %h %h expected EDC FFF 000 A5F",
                     mem[0], mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_threshold();
        randomize_model();
        model[0] = 12'h7A5; model[1] = 12'h666;
        load_ram();
        drive_pass("threshold", 2'b11, 0, 0, 1'b0);
        check_ram("threshold");
        checks++;
        if (mem[0] !== 12'hFF0 || mem[1] !== 12'h000) begin
            errors++;
            $display("[TB] FAIL threshold known: got %h %h expected FF0 000", mem[0], mem[1]);
        end
    endtask

    task automatic test_func_change_ignored();
        randomize_model();
        load_ram();
        drive_pass("restart_ignored", 2'b11, 0, 2, 1'b0);
        check_ram("restart_ignored");
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL restart_ignored idle cyc %0d: got busy %b done %b rd_en %b expected 0 0 0",
                         c, busy, done, rd_en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        randomize_model();
        load_ram();
        drive_pass("abort3", 2'b10, 3, 0, 1'b0);
        check_ram("abort3");
        #1;
        checks++;
        if (aborted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort3 aborted held: got %b expected 1", aborted);
        end
        @(negedge clk);
        drive_pass("abort1", 2'b01, 1, 0, 1'b0);
        check_ram("abort1");
    endtask

    task automatic test_reset_mid_pass();
        randomize_model();
        load_ram();
        func  = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_pass quiet cyc %0d: got wr_en %b rd_en %b busy %b expected 0 0 0",
                         c, wr_en, rd_en, busy);
            end
            @(negedge clk);
        end
        check_ram("reset_mid_pass");
        drive_pass("after_reset", 2'b01, 0, 0, 1'b0);
        check_ram("after_reset");
    endtask

    task automatic test_back_to_back();
        randomize_model();
        load_ram();
        drive_pass("b2b_first", 2'b10, 0, 0, 1'b1);
        drive_pass("b2b_second", 2'b00, 0, 0, 1'b0);
        check_ram("b2b");
    endtask

    task automatic test_random();
        logic [1:0] f;
        int ab;
        for (int k = 0; k < 6; k++) begin
            randomize_model();
            load_ram();
            f  = 2'($urandom_range(0, 3));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N)) : 0;
            drive_pass("random", f, ab, 0, 1'b0);
            check_ram("random");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        func     = 2'b00;
        load_req = 1'b0;
        rd_data  = 12'h000;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_invert();
        test_threshold();
        test_func_change_ignored();
        test_abort();
        test_back_to_back();
        test_reset_mid_pass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
